lz4_hash_table_nway: RTL

Parametrised N-way LZ4 match-finder hash table, the successor to the single-way 15-bit-key table. It sits between the LZ4 input byte window and the match-extension logic. It accepts one 4-byte sequence and its absolute position per cycle, and returns a hit or miss with the candidate match position after a fixed 3-cycle latency. It also inserts the new sequence using MRU replacement, clears itself after reset or on request, supports a write-only mode, and rejects candidates outside the LZ4 offset window.

---
 rtl/lz4_hash_pkg.sv | 19 +
 rtl/lz4_hash_sdp_ram.sv | 22 ++
 rtl/lz4_hash_table_nway.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lz4_hash_pkg.sv
// Shared types and defaults for the N-way LZ4 match-finder hash table.
package lz4_hash_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAN = 2'd2
   } state_t;

   localparam logic [31:0] DEF_HASH_COEF = 32'h9E3779B1;
   localparam int          DEF_WINDOW    = 65536;
   localparam int          PIPE_STAGES   = 3;

   // Width of one packed set: WAYS entries of {vld, data, addr}.
   function automatic int entry_w(input int ways, input int data_w, input int addr_w);
      return ways * (1 + data_w + addr_w);
   endfunction

endpackage

// File: rtl/lz4_hash_sdp_ram.sv
// Simple dual-port RAM, read-first, 1-cycle registered read.
module lz4_hash_sdp_ram #(
   parameter int AW = 15,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Write and registered read; a same-address read returns the old contents.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/lz4_hash_table_nway.sv
// N-way LZ4 match-finder hash table: 3-stage lookup with MRU insert,
// self-clearing after reset or on request, and LZ4 window check.
module lz4_hash_table_nway
   import lz4_hash_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          ADDR_W    = 32,
   parameter int          KEY_W     = 15,
   parameter int          WAYS      = 2,
   parameter logic [31:0] HASH_COEF = DEF_HASH_COEF,
   parameter int          WINDOW    = DEF_WINDOW,
   localparam int         WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              clean_req,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_wr_only,
   output logic              out_valid,
   output logic              out_hit,
   output logic [ADDR_W-1:0] out_addr,
   output logic [WAY_W-1:0]  out_way
);

   localparam int EW    = 1 + DATA_W + ADDR_W;
   localparam int SET_W = entry_w(WAYS, DATA_W, ADDR_W);
   localparam logic [ADDR_W:0] WIN_LIM = (ADDR_W+1)'(WINDOW);

   typedef logic [WAYS-1:0][EW-1:0] set_t;

   state_t               state, state_nxt;
   logic [KEY_W-1:0]     clr_cnt;
   logic [1:0]           drain_cnt;
   logic                 acc;
   logic [PIPE_STAGES-1:0] vld_pipe;

   // stage a: captured input plus registered hash key
   logic [DATA_W-1:0]    a_data;
   logic [ADDR_W-1:0]    a_addr;
   logic                 a_wr;
   logic [KEY_W-1:0]     a_key;
   // stage b: set returned from RAM (or forwarded), compare and write-back
   logic [DATA_W-1:0]    b_data;
   logic [ADDR_W-1:0]    b_addr;
   logic                 b_wr;
   logic [KEY_W-1:0]     b_key;
   logic                 fwd_sel;
   set_t                 fwd_set;

   logic [SET_W-1:0]     ram_rdata;
   logic                 ram_we;
   logic [KEY_W-1:0]     ram_waddr;
   logic [SET_W-1:0]     ram_wdata;

   set_t                 cur_set, new_set;
   logic [WAYS-1:0]      way_hit;
   logic                 hit_any;
   logic [WAY_W-1:0]     hit_way;
   logic [ADDR_W-1:0]    hit_addr;

   assign in_ready  = (state == ST_RUN);
   assign busy      = (state != ST_RUN);
   assign acc       = in_valid && in_ready;
   assign out_valid = vld_pipe[PIPE_STAGES-1];

   // Next state: clear the table, run, and drain the pipeline before a re-clear.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (clean_req) state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_cnt == 2'(PIPE_STAGES-1)) state_nxt = ST_CLEAN;
         ST_CLEAN: if (clr_cnt == {KEY_W{1'b1}}) state_nxt = ST_RUN;
         default:  state_nxt = ST_CLEAN;
      endcase
   end

   // State register, clear/drain counters, valid shift register and forward select.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= ST_CLEAN;
         clr_cnt   <= '0;
         drain_cnt <= '0;
         vld_pipe  <= '0;
         fwd_sel   <= 1'b0;
      end else begin
         state     <= state_nxt;
         clr_cnt   <= (state == ST_CLEAN) ? clr_cnt + 1'b1 : '0;
         drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
         vld_pipe  <= {vld_pipe[PIPE_STAGES-2:0], acc};
         // the RAM read in flight misses the write happening this cycle
         fwd_sel   <= vld_pipe[1] && vld_pipe[0] && (a_key == b_key);
      end
   end

   // Pipeline data path; only the key bits of the low product word are kept.
   always_ff @(posedge clk) begin
      if (acc) begin
         a_data <= in_data;
         a_addr <= in_addr;
         a_wr   <= in_wr_only;
         a_key  <= KEY_W'((32'(in_data) * HASH_COEF) >> (32 - KEY_W));
      end
      b_data  <= a_data;
      b_addr  <= a_addr;
      b_wr    <= a_wr;
      b_key   <= a_key;
      fwd_set <= new_set;
   end

   // Clearing owns the write port; otherwise stage b writes back its updated set.
   always_comb begin
      ram_we    = vld_pipe[1];
      ram_waddr = b_key;
      ram_wdata = new_set;
      if (state == ST_CLEAN) begin
         ram_we    = 1'b1;
         ram_waddr = clr_cnt;
         ram_wdata = '0;
      end
   end

   lz4_hash_sdp_ram #(.AW(KEY_W), .DW(SET_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (a_key),
      .rdata (ram_rdata)
   );

   assign cur_set = fwd_sel ? fwd_set : set_t'(ram_rdata);

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [ADDR_W-1:0] off;
      assign off = b_addr - cur_set[w][ADDR_W-1:0];
      assign way_hit[w] = cur_set[w][EW-1] &&
                          (cur_set[w][ADDR_W +: DATA_W] == b_data) &&
                          (off != '0) && ({1'b0, off} < WIN_LIM);
   end

   // MRU insert: new entry into way 0, older ways shift down, last dropped.
   always_comb begin
      new_set    = cur_set;
      new_set[0] = {1'b1, b_data, b_addr};
      for (int i = 1; i < WAYS; i++) new_set[i] = cur_set[i-1];
   end

   // Lowest-index hitting way wins.
   always_comb begin
      hit_any  = 1'b0;
      hit_way  = '0;
      hit_addr = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (way_hit[w]) begin
            hit_any  = 1'b1;
            hit_way  = WAY_W'(w);
            hit_addr = cur_set[w][ADDR_W-1:0];
         end
      end
   end

   // Output register; misses and write-only inserts report zeroes.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         out_hit  <= 1'b0;
         out_addr <= '0;
         out_way  <= '0;
      end else begin
         out_hit  <= vld_pipe[1] && hit_any && !b_wr;
         out_addr <= (vld_pipe[1] && hit_any && !b_wr) ? hit_addr : '0;
         out_way  <= (vld_pipe[1] && hit_any && !b_wr) ? hit_way  : '0;
      end
   end

endmodule
